// File: rtl/bcd_display_scan_if.sv
// ----------------------------------------------------------------------------
// bcd_display_scan_if
// Packed-BCD result bus from the binary-to-BCD converter into the display
// scanner: a 16-bit value {d3,d2,d1,d0} qualified by a one-cycle strobe.
// ----------------------------------------------------------------------------
interface bcd_display_scan_if;
   logic [15:0] bcd_in;
   logic        bcd_valid;

   modport master (
      output bcd_in,
      output bcd_valid
   );

   modport slave (
      input bcd_in,
      input bcd_valid
   );
endinterface

// File: rtl/bcd_display_scan.sv
// ----------------------------------------------------------------------------
// bcd_display_scan
// Captures a 4-digit packed BCD value on a strobe and drives a time-multiplexed
// 4-digit 7-segment display. New values are only adopted at a scan-frame
// boundary so a frame never mixes old and new digits. Optional leading-zero
// blanking; digits above 9 are shown as a dash and raise digit_err.
// ----------------------------------------------------------------------------
module bcd_display_scan #(
   parameter int REFRESH_DIV  = 50000,
   parameter int COMMON_ANODE = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   bcd_display_scan_if.slave        bus,
   input  logic                     blank_zeros,
   output logic [6:0]               seg,
   output logic [3:0]               an,
   output logic                     digit_err
);

   // A single-cycle dwell still needs a 1-bit counter to keep widths legal.
   localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   // Inactive levels; also used as XOR masks to apply output polarity.
   localparam logic [6:0]       SEG_OFF  = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
   localparam logic [3:0]       AN_OFF   = (COMMON_ANODE != 0) ? 4'hF  : 4'h0;

   // Logical segment pattern {g,f,e,d,c,b,a}; anything above 9 becomes a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // True when any of the four nibbles is not a legal BCD digit.
   function automatic logic has_bad_digit(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[i*4 +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   logic [15:0]      pending_r;
   logic [15:0]      shown_r;
   logic             pend_flag_r;
   logic [CNT_W-1:0] ref_cnt_r;
   logic [1:0]       idx_r;
   logic             digit_err_r;
   logic [6:0]       seg_r;
   logic [3:0]       an_r;

   logic             tc_s;
   logic             frame_end_s;
   logic [3:0]       digit_s;
   logic             blank_s;
   logic [6:0]       seg_logic_s;
   logic [3:0]       an_logic_s;

   assign tc_s        = (ref_cnt_r == CNT_LAST);
   assign frame_end_s = tc_s && (idx_r == 2'd3);

   // Dwell counter and digit index: advance to the next digit on terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt_r <= '0;
         idx_r     <= 2'd0;
      end else if (tc_s) begin
         ref_cnt_r <= '0;
         idx_r     <= idx_r + 2'd1;
      end else begin
         ref_cnt_r <= ref_cnt_r + CNT_W'(1);
      end
   end

   // Capture strobes into pending; hand pending over to shown at frame end.
   // A strobe on the boundary cycle lands in pending after the old value moved.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_r   <= 16'h0000;
         shown_r     <= 16'h0000;
         pend_flag_r <= 1'b0;
         digit_err_r <= 1'b0;
      end else begin
         if (frame_end_s) begin
            if (pend_flag_r) begin
               shown_r     <= pending_r;
               pend_flag_r <= 1'b0;
            end
            digit_err_r <= has_bad_digit(pending_r);
         end
         if (bus.bcd_valid) begin
            pending_r   <= bus.bcd_in;
            pend_flag_r <= 1'b1;
         end
      end
   end

   // Select the current digit, apply leading-zero blanking and decode.
   // A dash digit is nonzero, so it stops blanking of the digits below it.
   always_comb begin
      digit_s = 4'h0;
      blank_s = 1'b0;
      case (idx_r)
         2'd0: begin
            digit_s = shown_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            digit_s = shown_r[7:4];
            blank_s = blank_zeros && (shown_r[15:4] == 12'h000);
         end
         2'd2: begin
            digit_s = shown_r[11:8];
            blank_s = blank_zeros && (shown_r[15:8] == 8'h00);
         end
         2'd3: begin
            digit_s = shown_r[15:12];
            blank_s = blank_zeros && (shown_r[15:12] == 4'h0);
         end
         default: begin
            digit_s = 4'h0;
            blank_s = 1'b0;
         end
      endcase
      if (blank_s) begin
         seg_logic_s = 7'h00;
      end else begin
         seg_logic_s = seg_decode(digit_s);
      end
      an_logic_s = 4'b0001 << idx_r;
   end

   // Output register: one cycle behind idx, polarity applied by XOR mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_r <= SEG_OFF;
         an_r  <= AN_OFF;
      end else begin
         seg_r <= seg_logic_s ^ SEG_OFF;
         an_r  <= an_logic_s ^ AN_OFF;
      end
   end

   assign seg       = seg_r;
   assign an        = an_r;
   assign digit_err = digit_err_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_scan
// Directed bench for bcd_display_scan with REFRESH_DIV=4. Two instances share
// the input bus: one active-high (COMMON_ANODE=0) and one active-low
// (COMMON_ANODE=1), whose outputs must be the bitwise inverse. Expected frames
// are queued when the stimulus is driven and popped when the frame is scanned.
// One frame = 16 cycles; cyc counts edges since reset release, so frame
// boundaries fall on multiples of 16.
// ----------------------------------------------------------------------------
module tb_bcd_display_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic       blank_zeros;
   logic [6:0] seg_cc, seg_ca;
   logic [3:0] an_cc, an_ca;
   logic       err_cc, err_ca;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      string       tag;
      logic [27:0] segs;   // {d3,d2,d1,d0} logical segment patterns
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   bcd_display_scan_if bus ();

   bcd_display_scan #(.REFRESH_DIV(4), .COMMON_ANODE(0)) u_dut_cc (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .blank_zeros (blank_zeros),
      .seg         (seg_cc),
      .an          (an_cc),
      .digit_err   (err_cc)
   );

   bcd_display_scan #(.REFRESH_DIV(4), .COMMON_ANODE(1)) u_dut_ca (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .blank_zeros (blank_zeros),
      .seg         (seg_ca),
      .an          (an_ca),
      .digit_err   (err_ca)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      chk({tag, "/seg_cc"}, seg_cc, exp_seg);
      chk({tag, "/an_cc"}, {3'b000, an_cc}, {3'b000, exp_an});
      chk({tag, "/seg_ca"}, seg_ca, ~exp_seg);
      chk({tag, "/an_ca"}, {3'b000, an_ca}, {3'b000, ~exp_an});
   endtask

   task automatic check_err(input string tag, input logic exp_err);
      chk({tag, "/err_cc"}, {6'b000000, err_cc}, {6'b000000, exp_err});
      chk({tag, "/err_ca"}, {6'b000000, err_ca}, {6'b000000, exp_err});
   endtask

   task automatic push_exp(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0, input logic err);
      exp_t e;
      e.tag  = tag;
      e.segs = {s3, s2, s1, s0};
      e.err  = err;
      sb_q.push_back(e);
   endtask

   task automatic strobe(input logic [15:0] val);
      bus.bcd_in    = val;
      bus.bcd_valid = 1'b1;
      tick();
      bus.bcd_valid = 1'b0;
   endtask

   task automatic run_to_boundary();
      for (int n = 0; (n < 16) && ((cyc % 16) != 0); n++) begin
         tick();
      end
   endtask

   // Scan one full frame starting right after a boundary edge and compare it
   // with the next queued expectation. Optional strobes at frame offsets
   // inj_a / inj_b (1..16; 16 is the next boundary edge, 0 = none).
   task automatic check_frame(input int inj_a, input logic [15:0] val_a,
                              input int inj_b, input logic [15:0] val_b);
      exp_t       e;
      int         digit;
      logic [3:0] exp_an;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: no expectation queued (cyc %0d)", cyc);
      end else begin
         e = sb_q.pop_front();
         for (int k = 1; k <= 16; k++) begin
            if (k == inj_a) begin
               bus.bcd_in    = val_a;
               bus.bcd_valid = 1'b1;
            end else if (k == inj_b) begin
               bus.bcd_in    = val_b;
               bus.bcd_valid = 1'b1;
            end
            tick();
            bus.bcd_valid = 1'b0;
            digit  = (k - 1) / 4;
            exp_an = 4'b0001 << digit;
            check_outputs($sformatf("%s/d%0d", e.tag, digit), exp_an, e.segs[digit*7 +: 7]);
            if (k == 1) begin
               check_err(e.tag, e.err);
            end
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      blank_zeros   = 1'b0;
      bus.bcd_in    = 16'h0000;
      bus.bcd_valid = 1'b0;

      // Reset held three cycles: everything inactive.
      repeat (3) tick();
      check_outputs("reset", 4'h0, 7'h00);
      check_err("reset", 1'b0);

      // First edge after release lights digit 0 showing 0.
      reset = 1'b0;
      cyc   = 0;
      tick();
      check_outputs("release", 4'b0001, 7'h3F);

      // Plain scan of 1234.
      strobe(16'h1234);
      push_exp("scan1234", 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      // Leading-zero blanking.
      blank_zeros = 1'b1;
      strobe(16'h0070);
      push_exp("blank0070", 7'h00, 7'h00, 7'h07, 7'h3F, 1'b0);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      strobe(16'h0000);
      push_exp("blank0000", 7'h00, 7'h00, 7'h00, 7'h3F, 1'b0);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      // Tear-free: 2222 strobed while digit 1 is lit must wait a frame.
      blank_zeros = 1'b0;
      strobe(16'h1111);
      push_exp("tear1111", 7'h06, 7'h06, 7'h06, 7'h06, 1'b0);
      run_to_boundary();
      push_exp("tear2222", 7'h5B, 7'h5B, 7'h5B, 7'h5B, 1'b0);
      check_frame(6, 16'h2222, 0, 16'h0000);

      // Two strobes in one frame: 3333 is overwritten by 4444.
      push_exp("last4444", 7'h66, 7'h66, 7'h66, 7'h66, 1'b0);
      check_frame(3, 16'h3333, 10, 16'h4444);

      // Strobe on the boundary edge: 7777 (older) transfers, 5555 waits.
      push_exp("bnd7777", 7'h07, 7'h07, 7'h07, 7'h07, 1'b0);
      push_exp("bnd5555", 7'h6D, 7'h6D, 7'h6D, 7'h6D, 1'b0);
      check_frame(8, 16'h7777, 16, 16'h5555);
      check_frame(0, 16'h0000, 0, 16'h0000);
      check_frame(0, 16'h0000, 0, 16'h0000);

      // Invalid digit shows a dash and raises digit_err.
      strobe(16'h12A4);
      push_exp("err12A4", 7'h06, 7'h5B, 7'h40, 7'h66, 1'b1);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      // A dash counts as nonzero for blanking.
      blank_zeros = 1'b1;
      strobe(16'h0A00);
      push_exp("dash0A00", 7'h00, 7'h40, 7'h3F, 7'h3F, 1'b1);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      // Valid value clears digit_err at the next boundary.
      strobe(16'h0005);
      push_exp("clr0005", 7'h00, 7'h00, 7'h00, 7'h6D, 1'b0);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      // Mid-frame reset with an error shown and a value pending.
      strobe(16'h0A99);
      run_to_boundary();
      repeat (2) tick();
      strobe(16'h0333);
      tick();
      reset = 1'b1;
      tick();
      check_outputs("midreset", 4'h0, 7'h00);
      check_err("midreset", 1'b0);
      reset = 1'b0;
      cyc   = 0;
      tick();
      check_outputs("rerelease", 4'b0001, 7'h3F);
      push_exp("discard", 7'h00, 7'h00, 7'h00, 7'h3F, 1'b0);
      run_to_boundary();
      check_frame(0, 16'h0000, 0, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
